// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encodings and defaults for the bit-serial arithmetic blocks
package serial_arith_pkg;

  localparam int DEF_WIDTH = 8;

  // Encoding 2'd3 is unused; the FSM treats it as illegal and falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/half_adder.sv
// rtl/half_adder.sv - one-bit half adder, two of these form the serial adder slice
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_hs.sv
// rtl/serial_adder_hs.sv - bit-serial WIDTH-bit adder, LSB first, with start/busy/done handshake
module serial_adder_hs
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  logic             cout_q;
  logic             s1;
  logic             c1;
  logic             s_bit;
  logic             c2;
  logic             carry_nxt;

  // The single reused slice: two half adders, carry OR kept here.
  half_adder u_ha1 (.a(a_sr[0]), .b(b_sr[0]), .s(s1),    .c(c1));
  half_adder u_ha2 (.a(s1),      .b(carry),   .s(s_bit), .c(c2));

  assign carry_nxt = c1 | c2;

  // New bit enters at the MSB so that after WIDTH steps bit 0 lands at sum[0].
  always_comb begin
    sum_shift            = sum_q >> 1;
    sum_shift[WIDTH-1]   = s_bit;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            sum_q <= '0;
          end
        end
        ST_SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum_q <= sum_shift;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) cout_q <= carry_nxt;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_hs.sv
// tb/tb_serial_adder_hs.sv - randomized self-checking bench for serial_adder_hs at WIDTH 8, 4 and 1
module tb_serial_adder_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 0, cin8 = 0, busy8, done8, cout8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic       start4 = 0, cin4 = 0, busy4, done4, cout4;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  logic       start1 = 0, cin1 = 0, busy1, done1, cout1;
  logic [0:0] a1 = 0, b1 = 0, sum1;

  serial_adder_hs #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder_hs #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
  serial_adder_hs #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  int n_cmp  = 0;
  int n_fail = 0;
  int sel    = 8;

  logic        cur_busy, cur_done, cur_cout;
  logic [31:0] cur_sum;

  always_comb begin
    cur_busy = busy8; cur_done = done8; cur_cout = cout8; cur_sum = {24'd0, sum8};
    if (sel == 4) begin
      cur_busy = busy4; cur_done = done4; cur_cout = cout4; cur_sum = {28'd0, sum4};
    end else if (sel == 1) begin
      cur_busy = busy1; cur_done = done1; cur_cout = cout1; cur_sum = {31'd0, sum1};
    end
  end

  // Reference: {cout,sum} = a + b + cin with operands truncated to w bits.
  function automatic longint ref_add(input int w, input longint x, input longint y, input longint c);
    longint m;
    m = (longint'(1) << w) - 1;
    return (x & m) + (y & m) + c;
  endfunction

  task automatic drive(input int w, input logic st, input logic [31:0] ia, input logic [31:0] ib, input logic ic);
    case (w)
      4:       begin start4 = st; a4 = ia[3:0]; b4 = ib[3:0]; cin4 = ic; end
      1:       begin start1 = st; a1 = ia[0:0]; b1 = ib[0:0]; cin1 = ic; end
      default: begin start8 = st; a8 = ia[7:0]; b8 = ib[7:0]; cin8 = ic; end
    endcase
  endtask

  // Issues one op from IDLE and observes it; lat is the negedge index (0 = just after accept) of done.
  task automatic run_op(input int w, input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                        output logic [31:0] os, output logic oc, output int lat, output int bcnt,
                        output logic pd);
    sel = w;
    @(negedge clk); drive(w, 1'b1, ia, ib, ic);
    @(negedge clk); drive(w, 1'b0, ia, ib, ic);
    lat = -1; bcnt = 0; os = '0; oc = 1'b0;
    for (int m = 0; m < 40; m++) begin
      if (cur_busy) bcnt++;
      if (cur_done) begin
        lat = m; os = cur_sum; oc = cur_cout;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    pd = cur_done;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sum8, cout8, busy8, done8} !== 11'd0) begin
      n_fail++; $display("FAIL reset_w8: got sum=%h cout=%b busy=%b done=%b, expected all 0", sum8, cout8, busy8, done8);
    end
    n_cmp++;
    if ({sum4, cout4, busy4, done4, sum1, cout1, busy1, done1} !== 11'd0) begin
      n_fail++; $display("FAIL reset_w4_w1: got %h/%b/%b/%b %h/%b/%b/%b, expected all 0",
                         sum4, cout4, busy4, done4, sum1, cout1, busy1, done1);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sum8, cout8, busy8, done8} !== 11'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got sum=%h cout=%b busy=%b done=%b, expected all 0", sum8, cout8, busy8, done8);
    end
  endtask

  task automatic test_basic();
    logic [31:0] os; logic oc, pd; int lat, bc;
    run_op(8, 32'h35, 32'h4A, 1'b0, os, oc, lat, bc, pd);
    n_cmp++;
    if (os !== 32'h7F || oc !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: got sum=%h cout=%b, expected 7f/0", os, oc);
    end
    n_cmp++;
    if (lat !== 8 || bc !== 8) begin
      n_fail++; $display("FAIL basic_timing: got done_at=%0d busy_cycles=%0d, expected 8/8", lat, bc);
    end
    n_cmp++;
    if (pd !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_width: got done=%b one cycle later, expected 0", pd);
    end
  endtask

  task automatic test_carry_and_hold();
    logic [31:0] os; logic oc, pd; int lat, bc;
    run_op(8, 32'hFF, 32'h01, 1'b0, os, oc, lat, bc, pd);
    n_cmp++;
    if (os !== 32'h00 || oc !== 1'b1 || lat !== 8) begin
      n_fail++; $display("FAIL carry_ff_01: got sum=%h cout=%b lat=%0d, expected 00/1/8", os, oc, lat);
    end
    run_op(8, 32'hFF, 32'hFF, 1'b1, os, oc, lat, bc, pd);
    n_cmp++;
    if (os !== 32'hFF || oc !== 1'b1 || lat !== 8) begin
      n_fail++; $display("FAIL carry_ff_ff_1: got sum=%h cout=%b lat=%0d, expected ff/1/8", os, oc, lat);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (sum8 !== 8'hFF || cout8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
        n_fail++; $display("FAIL idle_hold[%0d]: got sum=%h cout=%b busy=%b done=%b, expected ff/1/0/0",
                           i, sum8, cout8, busy8, done8);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dn[$]; int bc;
    bc = 0;
    sel = 8;
    @(negedge clk); drive(8, 1'b1, 32'h10, 32'h20, 1'b0);
    for (int m = 0; m < 30; m++) begin
      @(negedge clk);
      if (cur_busy) bc++;
      if (cur_done) begin
        dn.push_back(m);
        n_cmp++;
        if (sum8 !== 8'h30 || cout8 !== 1'b0) begin
          n_fail++; $display("FAIL b2b_result@%0d: got sum=%h cout=%b, expected 30/0", m, sum8, cout8);
        end
      end
      if (m == 3) drive(8, 1'b1, 32'hFF, 32'hFF, 1'b1);
      if (m == 5) drive(8, 1'b1, 32'h10, 32'h20, 1'b0);
    end
    drive(8, 1'b0, 32'h10, 32'h20, 1'b0);
    n_cmp++;
    if (dn.size() !== 3) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d done cycles, expected 3", dn.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (dn[i] !== 8 + 10 * i) begin
          n_fail++; $display("FAIL b2b_done_time[%0d]: got cycle %0d, expected %0d", i, dn[i], 8 + 10 * i);
        end
      end
    end
    n_cmp++;
    if (bc !== 24) begin
      n_fail++; $display("FAIL b2b_busy_cycles: got %0d, expected 24", bc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] os; logic oc, pd; int lat, bc;
    sel = 8;
    @(negedge clk); drive(8, 1'b1, 32'h5A, 32'h3C, 1'b1);
    @(negedge clk); drive(8, 1'b0, 32'h5A, 32'h3C, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy8 !== 1'b1) begin
      n_fail++; $display("FAIL midop_busy: got busy=%b, expected 1", busy8);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({sum8, cout8, busy8, done8} !== 11'd0) begin
      n_fail++; $display("FAIL async_reset: got sum=%h cout=%b busy=%b done=%b, expected all 0", sum8, cout8, busy8, done8);
    end
    #1 rst = 1'b0;
    run_op(8, 32'h01, 32'h01, 1'b0, os, oc, lat, bc, pd);
    n_cmp++;
    if (os !== 32'h02 || oc !== 1'b0 || lat !== 8 || bc !== 8) begin
      n_fail++; $display("FAIL after_reset_op: got sum=%h cout=%b lat=%0d busy=%0d, expected 02/0/8/8", os, oc, lat, bc);
    end
  endtask

  task automatic test_random_w8();
    logic [31:0] os, ra, rb; logic oc, pd, rc; int lat, bc; longint r;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(0, 255); rb = $urandom_range(0, 255); rc = 1'($urandom_range(0, 1));
      r = ref_add(8, longint'(ra), longint'(rb), longint'(rc));
      run_op(8, ra, rb, rc, os, oc, lat, bc, pd);
      n_cmp++;
      if (os !== 32'(r & 'hFF) || oc !== r[8] || lat !== 8 || pd !== 1'b0) begin
        n_fail++; $display("FAIL rand_w8 %h+%h+%b: got sum=%h cout=%b lat=%0d, expected %h/%b/8",
                           ra[7:0], rb[7:0], rc, os, oc, lat, r & 'hFF, r[8]);
      end
    end
  endtask

  task automatic test_exhaustive_w4();
    logic [31:0] os; logic oc, pd; int lat, bc; longint r;
    for (int v = 0; v < 512; v++) begin
      r = ref_add(4, longint'(v & 15), longint'((v >> 4) & 15), longint'((v >> 8) & 1));
      run_op(4, 32'(v & 15), 32'((v >> 4) & 15), 1'((v >> 8) & 1), os, oc, lat, bc, pd);
      n_cmp++;
      if (os !== 32'(r & 'hF) || oc !== r[4] || lat !== 4 || bc !== 4) begin
        n_fail++; $display("FAIL exh_w4 v=%0d: got sum=%h cout=%b lat=%0d busy=%0d, expected %h/%b/4/4",
                           v, os, oc, lat, bc, r & 'hF, r[4]);
      end
    end
  endtask

  task automatic test_width1();
    logic [31:0] os; logic oc, pd; int lat, bc; longint r;
    run_op(1, 32'd1, 32'd1, 1'b1, os, oc, lat, bc, pd);
    n_cmp++;
    if (os !== 32'd1 || oc !== 1'b1 || lat !== 1 || bc !== 1 || pd !== 1'b0) begin
      n_fail++; $display("FAIL w1_111: got sum=%h cout=%b lat=%0d busy=%0d, expected 1/1/1/1", os, oc, lat, bc);
    end
    for (int v = 0; v < 8; v++) begin
      r = ref_add(1, longint'(v & 1), longint'((v >> 1) & 1), longint'((v >> 2) & 1));
      run_op(1, 32'(v & 1), 32'((v >> 1) & 1), 1'((v >> 2) & 1), os, oc, lat, bc, pd);
      n_cmp++;
      if (os !== 32'(r & 1) || oc !== r[1] || lat !== 1) begin
        n_fail++; $display("FAIL w1 v=%0d: got sum=%h cout=%b lat=%0d, expected %h/%b/1", v, os, oc, lat, r & 1, r[1]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry_and_hold();
    test_back_to_back();
    test_async_reset();
    test_random_w8();
    test_exhaustive_w4();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_hs.md
Name: serial_adder_hs

Overview:
- Bit-serial N-bit adder. Processes one bit per clock, LSB first.
- Each bit step uses a full-adder slice built from two half adders, with the carry held in a flip-flop.
- Start/busy/done handshake. A single adder slice is reused across all WIDTH bits.
- Addition companion to the team's combinational full-subtractor blocks. Intended for area-constrained datapaths where latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition. Sampled only in IDLE.
- a  input  WIDTH  operand A. Captured on the accepting edge.
- b  input  WIDTH  operand B. Captured on the accepting edge.
- cin  input  1  carry-in. Captured on the accepting edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse: sum/cout are final.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state is registered on the rising edge of clk.
- Reset (asserted at any time, including mid-operation):
  - state=IDLE, bit counter=0, carry=0, operand shift registers=0.
  - Outputs: sum=0, cout=0, busy=0, done=0.
  - Any in-flight operation is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0. sum/cout hold the last result.
  - start=1 at edge k: load A_sr<=a, B_sr<=b, carry<=cin, cnt<=0, sum<=0; go to SHIFT.
- SHIFT (busy=1):
  - Each edge computes the full-adder slice on A_sr[0], B_sr[0], carry:
    - HA1: s1=A^B, c1=A&B.
    - HA2: s=s1^carry, c2=s1&carry.
    - carry_next = c1|c2.
  - On the same edge: sum <= {s, sum[WIDTH-1:1]}; A_sr, B_sr shift right, zero fill; carry <= carry_next; cnt <= cnt+1.
  - When cnt==WIDTH-1 on an edge: that edge also sets cout<=carry_next and moves to DONE.
  - Exactly WIDTH shift edges: k+1 .. k+WIDTH.
- DONE:
  - done=1 for exactly one cycle, between edge k+WIDTH and edge k+WIDTH+1. busy=0.
  - Next edge returns unconditionally to IDLE.
- Latency:
  - done is high WIDTH+1 cycles after the cycle in which start was accepted.
  - The next start is accepted no earlier than edge k+WIDTH+2. Throughput is one op per WIDTH+2 cycles.
- start in SHIFT or DONE is ignored; no queuing. a/b/cin changes after acceptance have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- sum holds partial, shifting data while busy=1. It is valid from done until the next accepted start, and holds indefinitely in IDLE.
- WIDTH=1: one SHIFT edge (cnt==0==WIDTH-1), then DONE.
- Counter width: $clog2(WIDTH+1). The counter never wraps; it is reset on each accept.
- No combinational path from inputs to outputs. All outputs are registered or decoded from the state register only.

Decomposition:
- Shared package serial_arith_pkg:
  - State encodings: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Default width constant: DEF_WIDTH=8.
  - Encoding 2'd3 is illegal; the FSM recovers from it to IDLE.
- Sub-module half_adder (inputs a, b; outputs s=a^b, c=a&b). Instantiated twice inside serial_adder_hs to form the slice; the carry OR stays in the parent.
- No other sub-modules.

Test Plan:
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, one-cycle start -> busy high 8 cycles; done pulses on cycle 9 after accept; sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Results hold in IDLE for 20 idle cycles.
- start held high continuously with a=8'h10, b=8'h20 -> one op per 10 cycles; done exactly one cycle wide each time. Changing a/b mid-op does not alter the in-flight result 8'h30.
- Assert rst asynchronously (between clock edges) at cnt=4 of an op -> sum=0, cout=0, busy=0, done=0 immediately. A following op 8'h01+8'h01 yields 8'h02 with correct latency.
- Exhaustive check with WIDTH=4 over all a, b, cin (512 ops) against a+b+cin reference -> zero mismatches. WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1, done 2 cycles after accept.
